fetch_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end.
package cpu_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          PC_INC       = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs until decode takes them.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem read in flight and feeds decode through fetch_queue.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_rvalid,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_busy
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_e               state_r, state_s;
    logic [ADDR_W-1:0]          pc_r, pc_s;
    logic [ADDR_W-1:0]          addr_r, addr_s;
    logic                       drop_r, drop_s;
    logic                       issue_s, push_s, pop_s, rsp_s;
    logic [CNT_W-1:0]           count_s;
    logic [CNT_W:0]             occ_s;
    logic [ADDR_W+INSTR_W-1:0]  head_s;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({addr_r, imem_rdata}),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (count_s),
        .head      (head_s)
    );

    assign if_valid   = (count_s != CNT_W'(0)) && !redirect_valid;
    assign pop_s      = if_valid && if_ready;
    assign if_pc      = head_s[INSTR_W +: ADDR_W];
    assign if_instr   = head_s[INSTR_W-1:0];
    assign fetch_busy = (state_r == WAIT);
    assign imem_req   = issue_s;
    assign imem_addr  = issue_s ? pc_r : addr_r;

    // Next-state, issue and push decisions; redirect overrides everything else.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        addr_s  = addr_r;
        drop_s  = drop_r;
        issue_s = 1'b0;
        push_s  = 1'b0;
        rsp_s   = (state_r == WAIT) && imem_rvalid;
        // Entries the queue will hold once this cycle's pop and any in-flight word land;
        // a new request is only safe if that leaves room for its own response.
        occ_s   = {1'b0, count_s} - (CNT_W+1)'(pop_s)
                + (CNT_W+1)'((state_r == WAIT) && !(imem_rvalid && drop_r));

        if (redirect_valid) begin
            pc_s    = redirect_pc & ~ADDR_W'(3);
            drop_s  = (state_r == WAIT) && !imem_rvalid;
            state_s = drop_s ? WAIT : IDLE;
        end else begin
            if (rsp_s) begin
                push_s = !drop_r;
                drop_s = 1'b0;
            end else begin
                drop_s = drop_r;
            end
            issue_s = !reset && ((state_r == IDLE) || rsp_s)
                    && (occ_s < (CNT_W+1)'(FQ_DEPTH));
            if (issue_s) begin
                addr_s  = pc_r;
                pc_s    = pc_r + ADDR_W'(PC_INC);
                state_s = WAIT;
            end else if (rsp_s) begin
                state_s = IDLE;
            end else begin
                state_s = state_r;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            addr_r  <= addr_s;
            drop_r  <= drop_s;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a behavioural instruction memory of configurable latency.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_busy;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } out_t;

    logic [63:0] exp_addr[$];
    out_t        exp_out[$];

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int out_cnt  = 0;
    int mem_lat  = 1;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h8b1f03e5;
            64'h4:   return 32'hf84000a4;
            64'h8:   return 32'h8b040086;
            64'hC:   return 32'hf80010a6;
            default: return a[31:0] ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_out(input logic [63:0] pc);
        out_t e;
        e.pc    = pc;
        e.instr = mem_data(pc);
        exp_out.push_back(e);
    endtask

    // Memory: answers each request mem_lat cycles later with a one-cycle rvalid.
    initial begin
        int          pend;
        logic [63:0] pend_addr;
        pend        = 0;
        pend_addr   = 64'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(pend_addr);
                end
            end
            #2;
            if (imem_req) begin
                pend      = mem_lat;
                pend_addr = imem_addr;
            end
        end
    end

    // Monitor: compares every request address and every accepted output against the queues.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            #2;
            if (imem_req) begin
                req_cnt++;
                if (exp_addr.size() > 0) chk("req_addr", imem_addr, exp_addr.pop_front());
            end
            if (if_valid && if_ready) begin
                out_cnt++;
                if (exp_out.size() > 0) begin
                    e = exp_out.pop_front();
                    chk("out_pc", if_pc, e.pc);
                    chk("out_instr", 64'(if_instr), 64'(e.instr));
                end
            end
        end
    end

    task automatic start_test(input int lat, input logic rdy);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = rdy;
        mem_lat        = lat;
        repeat (3) @(negedge clk);
        exp_addr.delete();
        exp_out.delete();
        reset = 1'b0;
    endtask

    task automatic end_test(input string name);
        chk({name, "_addr_left"}, 64'(exp_addr.size()), 64'h0);
        chk({name, "_out_left"}, 64'(exp_out.size()), 64'h0);
    endtask

    task automatic wait_req(input logic [63:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #2;
            if (imem_req && imem_addr == a) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_req_seen", 64'(found), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, ob;
        reset          = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", 64'(if_valid), 64'h0);
        chk("rst_busy", 64'(fetch_busy), 64'h0);

        // 1-cycle memory streams one instruction per cycle
        start_test(1, 1'b1);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4);
        exp_addr.push_back(64'h8); exp_addr.push_back(64'hC);
        push_out(64'h0); push_out(64'h4); push_out(64'h8); push_out(64'hC);
        rb = req_cnt;
        ob = out_cnt;
        repeat (4) @(negedge clk);
        #1;
        chk("t1_req_4cyc", 64'(req_cnt - rb), 64'h4);
        repeat (2) @(negedge clk);
        #1;
        chk("t1_out_4cyc", 64'(out_cnt - ob), 64'h4);
        end_test("t1");

        // Decode stalled: queue fills after two requests, then drains and fetch resumes
        start_test(1, 1'b0);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4); exp_addr.push_back(64'h8);
        push_out(64'h0); push_out(64'h4); push_out(64'h8);
        rb = req_cnt;
        repeat (6) @(negedge clk);
        #3;
        chk("t2_req_cnt", 64'(req_cnt - rb), 64'h2);
        chk("t2_req_idle", 64'(imem_req), 64'h0);
        chk("t2_busy", 64'(fetch_busy), 64'h0);
        chk("t2_head_valid", 64'(if_valid), 64'h1);
        chk("t2_head_pc", if_pc, 64'h0);
        @(negedge clk);
        if_ready = 1'b1;
        repeat (5) @(negedge clk);
        end_test("t2");

        // Redirect while a slow request is in flight: stale word dropped
        start_test(3, 1'b1);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4); exp_addr.push_back(64'h8);
        exp_addr.push_back(64'h40); exp_addr.push_back(64'h44);
        push_out(64'h0); push_out(64'h40); push_out(64'h44);
        wait_req(64'h8);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        #3;
        chk("t3_redir_valid", 64'(if_valid), 64'h0);
        chk("t3_redir_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        chk("t3_flushed", 64'(if_valid), 64'h0);
        chk("t3_busy_drop", 64'(fetch_busy), 64'h1);
        repeat (12) @(negedge clk);
        end_test("t3");

        // Redirect coinciding with the response: data discarded, refetch next cycle
        start_test(3, 1'b1);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h4); exp_addr.push_back(64'h80);
        push_out(64'h0); push_out(64'h80);
        wait_req(64'h4);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        #3;
        chk("t4_redir_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        chk("t4_idle", 64'(fetch_busy), 64'h0);
        chk("t4_req", 64'(imem_req), 64'h1);
        chk("t4_addr", imem_addr, 64'h80);
        repeat (8) @(negedge clk);
        end_test("t4");

        // Reset while waiting; the late response lands during reset and is ignored
        start_test(3, 1'b1);
        exp_addr.push_back(64'h0); exp_addr.push_back(64'h0);
        push_out(64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            #3;
            chk("t5_rst_valid", 64'(if_valid), 64'h0);
            chk("t5_rst_req", 64'(imem_req), 64'h0);
            @(negedge clk);
        end
        reset = 1'b0;
        #3;
        chk("t5_post_valid", 64'(if_valid), 64'h0);
        chk("t5_post_req", 64'(imem_req), 64'h1);
        chk("t5_post_addr", imem_addr, 64'h0);
        @(negedge clk);
        #3;
        chk("t5_no_stale", 64'(if_valid), 64'h0);
        repeat (6) @(negedge clk);
        end_test("t5");

        // Misaligned redirect near the top of the address space wraps to zero
        start_test(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_addr.push_back(64'h0);
        push_out(64'hFFFF_FFFF_FFFF_FFFC); push_out(64'h0);
        #3;
        chk("t6_redir_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        chk("t6_req", 64'(imem_req), 64'h1);
        chk("t6_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (6) @(negedge clk);
        end_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
